// File: rtl/icode_sequencer_if.sv
// Load / playback / processor-side bundle for icode_sequencer.
// Breakpoint signals exist only when ICODE_SEQ_BREAKPOINT_EN is defined.
interface icode_sequencer_if #(
  parameter int ICODE_W = 8,
  parameter int ADDR_W  = 4
);
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [ICODE_W-1:0] load_data;
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  len;
  logic               loop_en;
  logic               icode_ready;
  logic [ICODE_W-1:0] ICODE;
  logic               icode_valid;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  pc;
`ifdef ICODE_SEQ_BREAKPOINT_EN
  logic               bp_en;
  logic [ADDR_W-1:0]  bp_addr;
  logic               resume;
  logic               paused;

  modport slave (
    input  load_en, load_addr, load_data, start, stop, len, loop_en, icode_ready,
           bp_en, bp_addr, resume,
    output ICODE, icode_valid, busy, done, pc, paused
  );
  modport master (
    output load_en, load_addr, load_data, start, stop, len, loop_en, icode_ready,
           bp_en, bp_addr, resume,
    input  ICODE, icode_valid, busy, done, pc, paused
  );
`else
  modport slave (
    input  load_en, load_addr, load_data, start, stop, len, loop_en, icode_ready,
    output ICODE, icode_valid, busy, done, pc
  );
  modport master (
    output load_en, load_addr, load_data, start, stop, len, loop_en, icode_ready,
    input  ICODE, icode_valid, busy, done, pc
  );
`endif
endinterface

// File: rtl/icode_sequencer.sv
// Program-playback source for the processor ICODE input: loadable program RAM,
// valid/ready playback with looping and stop. Optional breakpoint via ICODE_SEQ_BREAKPOINT_EN.
module icode_sequencer #(
  parameter int ICODE_W = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  icode_sequencer_if.slave bus
);

`ifdef ICODE_SEQ_BREAKPOINT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

  state_t             r_state;
  logic [ICODE_W-1:0] r_mem [DEPTH];
  logic [ICODE_W-1:0] r_icode;
  logic               r_valid;
  logic               r_done;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_last;
  logic               w_at_last;
  logic [ADDR_W-1:0]  w_next;

  // len==0 wraps to DEPTH-1 naturally because DEPTH == 2**ADDR_W
  assign w_at_last = (r_pc == r_last);
  assign w_next    = w_at_last ? '0 : ADDR_W'(r_pc + 1'b1);

`ifdef ICODE_SEQ_BREAKPOINT_EN
  logic r_bp_hold;
  logic w_bp_first;
  logic w_bp_next;
  // r_bp_hold suppresses the breakpoint just resumed from until a different entry shows
  assign w_bp_first = bus.bp_en && (bus.bp_addr == '0);
  assign w_bp_next  = bus.bp_en && (w_next == bus.bp_addr) && !r_bp_hold;
`endif

  // Program RAM is deliberately not reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (bus.load_en && r_state == IDLE) r_mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_icode <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_pc    <= '0;
      r_last  <= '0;
`ifdef ICODE_SEQ_BREAKPOINT_EN
      r_bp_hold <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.stop && bus.start) begin
            r_last <= ADDR_W'(bus.len - 1'b1);
            r_pc   <= '0;
`ifdef ICODE_SEQ_BREAKPOINT_EN
            r_bp_hold <= 1'b0;
            if (w_bp_first) r_state <= PAUSE; else
`endif
            begin
              r_state <= RUN;
              r_icode <= r_mem[0];
              r_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_icode <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
          end else if (r_valid && bus.icode_ready) begin
            if (w_at_last && !bus.loop_en) begin
              r_state <= IDLE;
              r_icode <= '0;
              r_valid <= 1'b0;
              r_pc    <= '0;
              r_done  <= 1'b1;
            end else
`ifdef ICODE_SEQ_BREAKPOINT_EN
            if (w_bp_next) begin
              r_state <= PAUSE;
              r_pc    <= w_next;
              r_icode <= '0;
              r_valid <= 1'b0;
            end else
`endif
            begin
              r_pc    <= w_next;
              r_icode <= r_mem[w_next];
`ifdef ICODE_SEQ_BREAKPOINT_EN
              if (w_next != bus.bp_addr) r_bp_hold <= 1'b0;
`endif
            end
          end
        end
`ifdef ICODE_SEQ_BREAKPOINT_EN
        PAUSE: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_pc    <= '0;
          end else if (bus.resume) begin
            r_state   <= RUN;
            r_icode   <= r_mem[r_pc];
            r_valid   <= 1'b1;
            r_bp_hold <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ICODE       = r_icode;
  assign bus.icode_valid = r_valid;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.pc          = r_pc;
`ifdef ICODE_SEQ_BREAKPOINT_EN
  assign bus.paused      = (r_state == PAUSE);
`endif

endmodule

// File: tb/tb_icode_sequencer.sv
// Bench for icode_sequencer: vector table, hand-written corner sequences,
// then random stimulus against a program-level reference model.
module tb_icode_sequencer;
  localparam int IW = 8, AW = 4, DEPTH = 16, NT = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icode_sequencer_if #(.ICODE_W(IW), .ADDR_W(AW)) bus();
  icode_sequencer #(.ICODE_W(IW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic          ld;
    logic [AW-1:0] la;
    logic [IW-1:0] dat;
    logic          st, sp;
    logic [AW-1:0] len;
    logic          lp, rdy;
    logic [IW-1:0] e_ic;
    logic          e_v, e_b, e_d;
    logic [AW-1:0] e_pc;
  } vec_t;

  int n_tot = 0, n_pass = 0;
  logic [IW-1:0] m_mem [DEPTH];
  vec_t tbl [NT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_outs(input string tag, input logic [IW-1:0] ic, input logic v, b, d,
                          input logic [AW-1:0] pc);
    chk({tag, " ICODE"}, 32'(bus.ICODE), 32'(ic));
    chk({tag, " valid"}, 32'(bus.icode_valid), 32'(v));
    chk({tag, " busy"},  32'(bus.busy), 32'(b));
    chk({tag, " done"},  32'(bus.done), 32'(d));
    chk({tag, " pc"},    32'(bus.pc), 32'(pc));
  endtask

  function automatic vec_t mk(input logic ld, input logic [AW-1:0] la, input logic [IW-1:0] dat,
                              input logic st, sp, input logic [AW-1:0] len, input logic lp, rdy);
    vec_t v;
    v = '{default: '0};
    v.ld = ld; v.la = la; v.dat = dat; v.st = st; v.sp = sp;
    v.len = len; v.lp = lp; v.rdy = rdy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.load_en = v.ld; bus.load_addr = v.la; bus.load_data = v.dat;
    bus.start = v.st; bus.stop = v.sp; bus.len = v.len;
    bus.loop_en = v.lp; bus.icode_ready = v.rdy;
  endtask

  // drive at the falling edge, sample 1 ns after the rising edge
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    bit m_run, m_done;
    int m_pc, m_last;
    logic [IW-1:0] m_ic;

    // ld la dat st sp len lp rdy | ICODE v b d pc
    tbl[0]  = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[3]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[4]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[5]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[6]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[7]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 4'd3};
    tbl[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[11] = '{1'b1, 4'd3, 8'hAA, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[12] = '{1'b1, 4'd3, 8'hAA, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[13] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 4'd3};
    tbl[14] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[15] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[16] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[17] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[18] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};

    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef ICODE_SEQ_BREAKPOINT_EN
    bus.bp_en = 1'b0; bus.bp_addr = '0; bus.resume = 1'b0;
`endif
    #11;
    chk_outs("reset", 8'h00, 0, 0, 0, 4'd0);
    #1 rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      step(mk(1, 4'(i), 8'(i + 'h10), 0, 0, 0, 0, 0));
      m_mem[i] = 8'(i + 'h10);
    end

    for (int i = 0; i < NT; i++) begin
      step(mk(tbl[i].ld, tbl[i].la, tbl[i].dat, tbl[i].st, tbl[i].sp, tbl[i].len, tbl[i].lp, tbl[i].rdy));
      chk_outs($sformatf("row%0d", i), tbl[i].e_ic, tbl[i].e_v, tbl[i].e_b, tbl[i].e_d, tbl[i].e_pc);
    end

    // full-depth looping run: 20 accepted cycles, pc wraps 15 -> 0
    step(mk(0, 0, 0, 1, 0, 4'd0, 1, 1));
    chk_outs("loop0", 8'h10, 1, 1, 0, 4'd0);
    for (int k = 1; k < 20; k++) begin
      step(mk(0, 0, 0, 0, 0, 4'd0, 1, 1));
      chk_outs($sformatf("loop%0d", k), 8'(8'h10 + (k % 16)), 1, 1, 0, 4'(k % 16));
    end
    step(mk(0, 0, 0, 0, 1, 4'd0, 1, 1));
    chk_outs("loopstop", 8'h00, 0, 0, 0, 4'd0);

    // stop mid-run at pc=5
    step(mk(0, 0, 0, 1, 0, 4'd0, 0, 1));
    for (int k = 1; k <= 5; k++) step(mk(0, 0, 0, 0, 0, 4'd0, 0, 1));
    chk_outs("pre-stop", 8'h15, 1, 1, 0, 4'd5);
    step(mk(0, 0, 0, 0, 1, 4'd0, 0, 1));
    chk_outs("stop", 8'h00, 0, 0, 0, 4'd0);
    step(mk(0, 0, 0, 0, 0, 4'd0, 0, 1));
    chk_outs("post-stop", 8'h00, 0, 0, 0, 4'd0);

    // asynchronous reset mid-run, program retained
    step(mk(0, 0, 0, 1, 0, 4'd0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 4'd0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 4'd0, 1, 1));
    chk_outs("pre-rst", 8'h12, 1, 1, 0, 4'd2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_outs("async-rst", 8'h00, 0, 0, 0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 1, 0, 4'd4, 0, 1));
    for (int k = 0; k < 4; k++) begin
      chk_outs($sformatf("rerun%0d", k), 8'(8'h10 + k), 1, 1, 0, 4'(k));
      step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    end
    chk_outs("rerun-done", 8'h00, 0, 0, 1, 4'd0);

`ifdef ICODE_SEQ_BREAKPOINT_EN
    bus.bp_en = 1'b1; bus.bp_addr = 4'd2;
    step(mk(0, 0, 0, 1, 0, 4'd4, 0, 1));
    chk_outs("bp0", 8'h10, 1, 1, 0, 4'd0);
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    chk_outs("bp1", 8'h11, 1, 1, 0, 4'd1);
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    chk_outs("bp-pause", 8'h00, 0, 1, 0, 4'd2);
    chk("bp paused", 32'(bus.paused), 32'd1);
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    chk("bp held", 32'(bus.paused), 32'd1);
    bus.resume = 1'b1;
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    bus.resume = 1'b0;
    chk_outs("bp-resume", 8'h12, 1, 1, 0, 4'd2);
    chk("bp unpaused", 32'(bus.paused), 32'd0);
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    chk_outs("bp3", 8'h13, 1, 1, 0, 4'd3);
    step(mk(0, 0, 0, 0, 0, 4'd4, 0, 1));
    chk_outs("bp-done", 8'h00, 0, 0, 1, 4'd0);
    bus.bp_en = 1'b0;
`endif

    // random traffic vs. program-level model (entry index + run flag)
    m_run = 0; m_done = 0; m_pc = 0; m_last = 0; m_ic = '0;
    for (int c = 0; c < 600; c++) begin
      v = mk($urandom % 4 == 0, 4'($urandom), 8'($urandom), $urandom % 6 == 0,
             $urandom % 16 == 0, 4'($urandom), $urandom % 3 == 0, $urandom % 4 != 0);
      m_done = 0;
      if (!m_run) begin
        if (!v.sp && v.st) begin
          m_run = 1; m_pc = 0;
          m_last = (v.len == 0 ? DEPTH : int'(v.len)) - 1;
          m_ic = m_mem[0];
        end
        if (v.ld) m_mem[v.la] = v.dat;
      end else if (v.sp) begin
        m_run = 0; m_pc = 0; m_ic = '0;
      end else if (v.rdy) begin
        if (m_pc == m_last) begin
          if (v.lp) m_pc = 0;
          else begin m_run = 0; m_pc = 0; m_done = 1; end
        end else m_pc++;
        m_ic = m_run ? m_mem[m_pc] : 8'h00;
      end
      step(v);
      chk_outs($sformatf("rand%0d", c), m_ic, m_run, m_run, m_done, 4'(m_pc));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
